// File: rtl/fpu_divsqrt_ctrl_pkg.sv
// Shared encodings for the FP divide/sqrt sequencer: FSM states, op codes,
// exception flag positions, FClass bit order and IEEE single constants.
package fpu_divsqrt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_WAIT     = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    typedef enum logic {
        OP_DIV  = 1'b0,
        OP_SQRT = 1'b1
    } op_e;

    localparam int FLAG_W  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF   = 32'h7F800000;
    localparam logic [31:0] ONE_F32   = 32'h3F800000;

    localparam int CLS_W        = 10;
    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;

    typedef logic [CLS_W-1:0] fclass_t;

endpackage

// File: rtl/fpu_divsqrt_ctrl_special.sv
// IEEE special-case resolver for divide and square root.
// Purely combinational; flags the operands the iterative core never sees.
module fpu_divsqrt_ctrl_special
    import fpu_divsqrt_ctrl_pkg::*;
#(
    parameter int FLen = 32
) (
    input  fclass_t           cls_a_i,
    input  fclass_t           cls_b_i,
    input  logic              sign_a_i,
    input  logic              sign_b_i,
    input  logic              op_i,
    output logic              is_special_o,
    output logic [FLen-1:0]   result_o,
    output logic [FLAG_W-1:0] flags_o
);

    logic nan_a, nan_b, snan_a, snan_b;
    logic inf_a, inf_b, zero_a, zero_b;
    logic fin_a, fin_b, sign_r;

    assign snan_a = cls_a_i[CLS_SNAN];
    assign snan_b = cls_b_i[CLS_SNAN];
    assign nan_a  = snan_a | cls_a_i[CLS_QNAN];
    assign nan_b  = snan_b | cls_b_i[CLS_QNAN];
    assign inf_a  = cls_a_i[CLS_NEG_INF] | cls_a_i[CLS_POS_INF];
    assign inf_b  = cls_b_i[CLS_NEG_INF] | cls_b_i[CLS_POS_INF];
    assign zero_a = cls_a_i[CLS_NEG_ZERO] | cls_a_i[CLS_POS_ZERO];
    assign zero_b = cls_b_i[CLS_NEG_ZERO] | cls_b_i[CLS_POS_ZERO];
    assign fin_a  = |{cls_a_i[CLS_NEG_NORM], cls_a_i[CLS_NEG_SUB],
                      cls_a_i[CLS_POS_SUB], cls_a_i[CLS_POS_NORM]};
    assign fin_b  = |{cls_b_i[CLS_NEG_NORM], cls_b_i[CLS_NEG_SUB],
                      cls_b_i[CLS_POS_SUB], cls_b_i[CLS_POS_NORM]};
    assign sign_r = sign_a_i ^ sign_b_i;

    always_comb begin
        is_special_o = 1'b0;
        result_o     = '0;
        flags_o      = '0;
        if (op_i == OP_SQRT) begin
            if (nan_a) begin
                is_special_o     = 1'b1;
                result_o         = FLen'(CANON_NAN);
                flags_o[FLAG_NV] = snan_a;
            end else if (zero_a) begin
                is_special_o = 1'b1;
                result_o     = {sign_a_i, {(FLen-1){1'b0}}};
            end else if (sign_a_i) begin
                is_special_o     = 1'b1;
                result_o         = FLen'(CANON_NAN);
                flags_o[FLAG_NV] = 1'b1;
            end else if (inf_a) begin
                is_special_o = 1'b1;
                result_o     = FLen'(POS_INF);
            end
        end else begin
            if (nan_a | nan_b) begin
                is_special_o     = 1'b1;
                result_o         = FLen'(CANON_NAN);
                flags_o[FLAG_NV] = snan_a | snan_b;
            end else if ((inf_a & inf_b) | (zero_a & zero_b)) begin
                is_special_o     = 1'b1;
                result_o         = FLen'(CANON_NAN);
                flags_o[FLAG_NV] = 1'b1;
            end else if (fin_a & zero_b) begin
                is_special_o     = 1'b1;
                result_o         = FLen'({sign_r, POS_INF[30:0]});
                flags_o[FLAG_DZ] = 1'b1;
            end else if (inf_a) begin
                is_special_o = 1'b1;
                result_o     = FLen'({sign_r, POS_INF[30:0]});
            end else if ((zero_a & (fin_b | inf_b)) | (fin_a & inf_b)) begin
                is_special_o = 1'b1;
                result_o     = {sign_r, {(FLen-1){1'b0}}};
            end
        end
    end

endmodule

// File: rtl/fpu_divsqrt_ctrl.sv
// Sequencer for the shared iterative FP divide/sqrt datapath: classifies
// operands, short-circuits IEEE special cases and babysits the core.
module fpu_divsqrt_ctrl
    import fpu_divsqrt_ctrl_pkg::*;
#(
    parameter int FLen     = 32,
    parameter int ExpLen   = 8,
    parameter int SigLen   = 23,
    parameter int MAX_WAIT = 64
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_op_i,
    input  logic [FLen-1:0]          req_rs1_i,
    input  logic [FLen-1:0]          req_rs2_i,
    input  logic [2:0]               req_rm_i,
    input  logic                     flush_i,
    output logic                     core_start_o,
    output logic                     core_kill_o,
    output logic                     core_op_o,
    output logic [2:0]               core_rm_o,
    output logic signed [ExpLen+1:0] core_expA_o,
    output logic [SigLen:0]          core_sigA_o,
    output logic signed [ExpLen+1:0] core_expB_o,
    output logic [SigLen:0]          core_sigB_o,
    output logic                     core_sign_o,
    input  logic                     core_done_i,
    input  logic [FLen-1:0]          core_result_i,
    input  logic [FLAG_W-1:0]        core_flags_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [FLen-1:0]          rsp_result_o,
    output logic [FLAG_W-1:0]        rsp_flags_o,
    output logic                     timeout_o
);

    localparam int         Bias     = (1 << (ExpLen - 1)) - 1;
    localparam logic [6:0] WaitLast = 7'(MAX_WAIT - 1);

    state_e              state_q, state_d;
    logic                op_q, op_d;
    logic [2:0]          rm_q, rm_d;
    logic [FLen-1:0]     rs1_q, rs1_d;
    logic [FLen-1:0]     rs2_q, rs2_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [FLen-1:0]     res_q, res_d;
    logic [FLAG_W-1:0]   flg_q, flg_d;
    logic                tmo_q, tmo_d;

    fclass_t             cls_a, cls_b;
    logic                sign_a, sign_b;
    logic                spec_hit;
    logic [FLen-1:0]     spec_res;
    logic [FLAG_W-1:0]   spec_flg;
    logic                start, kill;

    function automatic fclass_t fclass(input logic [FLen-1:0] x);
        logic              s;
        logic [ExpLen-1:0] e;
        logic [SigLen-1:0] f;
        fclass_t           c;
        s = x[FLen-1];
        e = x[FLen-2 -: ExpLen];
        f = x[SigLen-1:0];
        c = '0;
        if (&e) begin
            if (f == '0)          c[s ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
            else if (f[SigLen-1]) c[CLS_QNAN] = 1'b1;
            else                  c[CLS_SNAN] = 1'b1;
        end else if (e == '0) begin
            if (f == '0) c[s ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
            else         c[s ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
        end else begin
            c[s ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
        end
        return c;
    endfunction

    function automatic int lzc(input logic [SigLen-1:0] f);
        int n;
        n = SigLen;
        for (int i = 0; i < SigLen; i++) begin
            if (f[i]) n = SigLen - 1 - i;
        end
        return n;
    endfunction

    // Zero, inf and NaN unpack to all-zero; only finite nonzero reaches the core.
    function automatic logic [ExpLen+1:0] unp_exp(input logic [FLen-1:0] x);
        logic [ExpLen-1:0] e;
        logic [SigLen-1:0] f;
        int                v;
        e = x[FLen-2 -: ExpLen];
        f = x[SigLen-1:0];
        if ((&e) || (e == '0 && f == '0)) v = 0;
        else if (e == '0)                 v = -Bias - lzc(f);
        else                              v = int'(e) - Bias;
        return (ExpLen+2)'(v);
    endfunction

    function automatic logic [SigLen:0] unp_sig(input logic [FLen-1:0] x);
        logic [ExpLen-1:0] e;
        logic [SigLen-1:0] f;
        logic [SigLen-1:0] sh;
        logic [SigLen:0]   r;
        e = x[FLen-2 -: ExpLen];
        f = x[SigLen-1:0];
        sh = f << (lzc(f) + 1);
        if ((&e) || (e == '0 && f == '0)) r = '0;
        else if (e == '0)                 r = {1'b1, sh};
        else                              r = {1'b1, f};
        return r;
    endfunction

    assign cls_a  = fclass(rs1_q);
    assign cls_b  = fclass(rs2_q);
    assign sign_a = rs1_q[FLen-1];
    assign sign_b = rs2_q[FLen-1];

    fpu_divsqrt_ctrl_special #(
        .FLen(FLen)
    ) u_special (
        .cls_a_i      (cls_a),
        .cls_b_i      (cls_b),
        .sign_a_i     (sign_a),
        .sign_b_i     (sign_b),
        .op_i         (op_q),
        .is_special_o (spec_hit),
        .result_o     (spec_res),
        .flags_o      (spec_flg)
    );

    assign start        = (state_q == ST_CLASSIFY) && !spec_hit;
    assign req_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign core_start_o = start;
    assign core_kill_o  = kill;
    assign core_op_o    = op_q;
    assign core_rm_o    = rm_q;
    assign core_expA_o  = unp_exp(rs1_q);
    assign core_sigA_o  = unp_sig(rs1_q);
    assign core_expB_o  = unp_exp(rs2_q);
    assign core_sigB_o  = unp_sig(rs2_q);
    assign core_sign_o  = sign_a ^ sign_b;
    assign rsp_result_o = res_q;
    assign rsp_flags_o  = flg_q;
    assign timeout_o    = tmo_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rm_d    = rm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flg_d   = flg_q;
        tmo_d   = tmo_q;
        kill    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    rm_d    = req_rm_i;
                    rs1_d   = req_rs1_i;
                    rs2_d   = (req_op_i == OP_SQRT) ? FLen'(ONE_F32) : req_rs2_i;
                    state_d = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                cnt_d = '0;
                if (spec_hit) begin
                    res_d   = spec_res;
                    flg_d   = spec_flg;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 7'd1;
                if (core_done_i) begin
                    res_d   = core_result_i;
                    flg_d   = core_flags_i;
                    state_d = ST_RESP;
                end else if (cnt_q == WaitLast) begin
                    kill           = 1'b1;
                    tmo_d          = 1'b1;
                    res_d          = FLen'(CANON_NAN);
                    flg_d          = '0;
                    flg_d[FLAG_NV] = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides everything: no accept, no response, no timeout.
        if (flush_i) begin
            state_d = ST_IDLE;
            op_d    = op_q;
            rm_d    = rm_q;
            rs1_d   = rs1_q;
            rs2_d   = rs2_q;
            res_d   = res_q;
            flg_d   = flg_q;
            tmo_d   = tmo_q;
            kill    = (state_q == ST_WAIT) || start;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            op_q    <= 1'b0;
            rm_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rm_q    <= rm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_fpu_divsqrt_ctrl.sv
// Directed bench for the divide/sqrt sequencer with a hand-driven core model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fpu_divsqrt_ctrl;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_op_i;
    logic [31:0] req_rs1_i;
    logic [31:0] req_rs2_i;
    logic [2:0]  req_rm_i;
    logic        flush_i;
    logic        core_start_o;
    logic        core_kill_o;
    logic        core_op_o;
    logic [2:0]  core_rm_o;
    logic [9:0]  core_expA_o;
    logic [23:0] core_sigA_o;
    logic [9:0]  core_expB_o;
    logic [23:0] core_sigB_o;
    logic        core_sign_o;
    logic        core_done_i;
    logic [31:0] core_result_i;
    logic [4:0]  core_flags_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic [4:0]  rsp_flags_o;
    logic        timeout_o;

    fpu_divsqrt_ctrl #(
        .MAX_WAIT(16)
    ) dut (
        .clk_i         (clk_i),
        .resetn_i      (resetn_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_rm_i      (req_rm_i),
        .flush_i       (flush_i),
        .core_start_o  (core_start_o),
        .core_kill_o   (core_kill_o),
        .core_op_o     (core_op_o),
        .core_rm_o     (core_rm_o),
        .core_expA_o   (core_expA_o),
        .core_sigA_o   (core_sigA_o),
        .core_expB_o   (core_expB_o),
        .core_sigB_o   (core_sigB_o),
        .core_sign_o   (core_sign_o),
        .core_done_i   (core_done_i),
        .core_result_i (core_result_i),
        .core_flags_i  (core_flags_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_result_o  (rsp_result_o),
        .rsp_flags_o   (rsp_flags_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;
    int n_start = 0;
    int n_kill  = 0;

    always @(posedge clk_i) begin
        if (core_start_o) n_start <= n_start + 1;
        if (core_kill_o)  n_kill  <= n_kill + 1;
    end

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t sv [0:13];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic nxt();
        @(negedge clk_i);
        #1;
    endtask

    // Returns in the cycle after acceptance (CLASSIFY), 1ns past the falling edge.
    task automatic issue(input logic op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_rs1_i   = a;
        req_rs2_i   = b;
        #1;
        chk("acc_ready", req_ready_o, 1);
        nxt();
        req_valid_i = 1'b0;
    endtask

    task automatic take();
        rsp_ready_i = 1'b1;
        nxt();
        rsp_ready_i = 1'b0;
        chk("take_idle", req_ready_o, 1);
        chk("take_novalid", rsp_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got stuck want finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int k0;
        sv[0]  = '{1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08};
        sv[1]  = '{1'b1, 32'hC0800000, 32'h12345678, 32'h7FC00000, 5'h10};
        sv[2]  = '{1'b1, 32'h80000000, 32'h12345678, 32'h80000000, 5'h00};
        sv[3]  = '{1'b0, 32'h00000000, 32'h80000000, 32'h7FC00000, 5'h10};
        sv[4]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'h10};
        sv[5]  = '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 5'h00};
        sv[6]  = '{1'b0, 32'hBF800000, 32'h7F800000, 32'h80000000, 5'h00};
        sv[7]  = '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10};
        sv[8]  = '{1'b0, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 5'h00};
        sv[9]  = '{1'b1, 32'h7F800000, 32'h00000000, 32'h7F800000, 5'h00};
        sv[10] = '{1'b1, 32'hFF800000, 32'h00000000, 32'h7FC00000, 5'h10};
        sv[11] = '{1'b0, 32'h00000000, 32'hC0000000, 32'h80000000, 5'h00};
        sv[12] = '{1'b0, 32'h40000000, 32'h80000000, 32'hFF800000, 5'h08};
        sv[13] = '{1'b1, 32'h7F800001, 32'h00000000, 32'h7FC00000, 5'h10};

        resetn_i = 1'b0; req_valid_i = 1'b0; req_op_i = 1'b0;
        req_rs1_i = '0; req_rs2_i = '0; req_rm_i = '0; flush_i = 1'b0;
        core_done_i = 1'b0; core_result_i = '0; core_flags_i = '0;
        rsp_ready_i = 1'b0;
        repeat (2) nxt();
        chk("rst_ready", req_ready_o, 1);
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_start", core_start_o, 0);
        chk("rst_kill", core_kill_o, 0);
        chk("rst_tmo", timeout_o, 0);
        chk("rst_res", rsp_result_o, 0);
        chk("rst_flg", rsp_flags_o, 0);
        chk("rst_expA", core_expA_o, 0);
        chk("rst_sigB", core_sigB_o, 0);
        resetn_i = 1'b1;

        // Special-case fast path: response two cycles after accept, no start.
        s0 = n_start;
        for (int i = 0; i < 14; i++) begin
            issue(sv[i].op, sv[i].a, sv[i].b);
            chk($sformatf("sp%0d_nostart", i), core_start_o, 0);
            chk($sformatf("sp%0d_early", i), rsp_valid_o, 0);
            nxt();
            chk($sformatf("sp%0d_valid", i), rsp_valid_o, 1);
            chk($sformatf("sp%0d_res", i), rsp_result_o, sv[i].res);
            chk($sformatf("sp%0d_flg", i), rsp_flags_o, sv[i].flg);
            take();
        end
        chk("sp_startcnt", n_start - s0, 0);

        // Normal divide 6/3 through the core.
        s0 = n_start;
        req_rm_i = 3'd3;
        issue(1'b0, 32'h40C00000, 32'h40400000);
        chk("d_start", core_start_o, 1);
        chk("d_expA", core_expA_o, 2);
        chk("d_sigA", core_sigA_o, 24'hC00000);
        chk("d_expB", core_expB_o, 1);
        chk("d_sigB", core_sigB_o, 24'hC00000);
        chk("d_sign", core_sign_o, 0);
        chk("d_op", core_op_o, 0);
        chk("d_rm", core_rm_o, 3);
        nxt();
        chk("d_start1", core_start_o, 0);
        repeat (3) nxt();
        chk("d_nvalid", rsp_valid_o, 0);
        nxt();
        core_done_i = 1'b1; core_result_i = 32'h40000000; core_flags_i = 5'h00;
        nxt();
        core_done_i = 1'b0;
        chk("d_valid", rsp_valid_o, 1);
        chk("d_res", rsp_result_o, 32'h40000000);
        chk("d_flg", rsp_flags_o, 0);
        chk("d_hold_expA", core_expA_o, 2);
        chk("d_startcnt", n_start - s0, 1);
        take();

        // Done while idle must be ignored.
        core_done_i = 1'b1; core_result_i = 32'hDEADBEEF; core_flags_i = 5'h1F;
        nxt();
        core_done_i = 1'b0;
        chk("idle_done_valid", rsp_valid_o, 0);
        chk("idle_done_res", rsp_result_o, 32'h40000000);
        chk("idle_done_flg", rsp_flags_o, 0);

        // Subnormal sqrt with response back-pressure.
        req_rm_i = 3'd0;
        issue(1'b1, 32'h00000001, 32'hAAAAAAAA);
        chk("s_start", core_start_o, 1);
        chk("s_expA", core_expA_o, 10'h36B);
        chk("s_sigA", core_sigA_o, 24'h800000);
        chk("s_expB", core_expB_o, 0);
        chk("s_sigB", core_sigB_o, 24'h800000);
        chk("s_op", core_op_o, 1);
        nxt();
        core_done_i = 1'b1; core_result_i = 32'h1A3504F3; core_flags_i = 5'h01;
        nxt();
        core_done_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s_hold%0d_valid", i), rsp_valid_o, 1);
            chk($sformatf("s_hold%0d_res", i), rsp_result_o, 32'h1A3504F3);
            chk($sformatf("s_hold%0d_flg", i), rsp_flags_o, 5'h01);
            chk($sformatf("s_hold%0d_rdy", i), req_ready_o, 0);
            nxt();
        end
        take();

        // Flush while waiting on the core.
        k0 = n_kill;
        issue(1'b0, 32'h40C00000, 32'h40400000);
        nxt();
        flush_i = 1'b1;
        #1;
        chk("fw_kill", core_kill_o, 1);
        nxt();
        flush_i = 1'b0;
        chk("fw_kill_off", core_kill_o, 0);
        chk("fw_ready", req_ready_o, 1);
        core_done_i = 1'b1; core_result_i = 32'h11111111;
        nxt();
        core_done_i = 1'b0;
        chk("fw_novalid", rsp_valid_o, 0);
        chk("fw_killcnt", n_kill - k0, 1);

        // Flush in IDLE blocks acceptance.
        req_valid_i = 1'b1; flush_i = 1'b1;
        nxt();
        req_valid_i = 1'b0; flush_i = 1'b0;
        chk("fi_ready", req_ready_o, 1);
        nxt();
        chk("fi_ready2", req_ready_o, 1);

        // Flush during CLASSIFY while start is high.
        issue(1'b0, 32'h40C00000, 32'h40400000);
        flush_i = 1'b1;
        #1;
        chk("fc_start", core_start_o, 1);
        chk("fc_kill", core_kill_o, 1);
        nxt();
        flush_i = 1'b0;
        chk("fc_ready", req_ready_o, 1);

        // Flush in RESP drops the response.
        issue(1'b0, 32'h3F800000, 32'h00000000);
        nxt();
        chk("fr_valid", rsp_valid_o, 1);
        flush_i = 1'b1;
        nxt();
        flush_i = 1'b0;
        chk("fr_novalid", rsp_valid_o, 0);
        chk("fr_ready", req_ready_o, 1);

        // Done on the watchdog's last cycle wins.
        issue(1'b0, 32'h40C00000, 32'h40400000);
        repeat (15) nxt();
        chk("dw_nvalid", rsp_valid_o, 0);
        nxt();
        core_done_i = 1'b1; core_result_i = 32'h3F000000; core_flags_i = 5'h00;
        #1;
        chk("dw_nokill", core_kill_o, 0);
        nxt();
        core_done_i = 1'b0;
        chk("dw_valid", rsp_valid_o, 1);
        chk("dw_res", rsp_result_o, 32'h3F000000);
        chk("dw_tmo", timeout_o, 0);
        take();

        // Watchdog expiry with no done.
        issue(1'b0, 32'h40C00000, 32'h40400000);
        for (int k = 1; k < 16; k++) begin
            nxt();
            chk($sformatf("to_w%0d_kill", k), core_kill_o, 0);
        end
        nxt();
        chk("to_kill", core_kill_o, 1);
        chk("to_tmo_pre", timeout_o, 0);
        nxt();
        chk("to_kill_off", core_kill_o, 0);
        chk("to_valid", rsp_valid_o, 1);
        chk("to_res", rsp_result_o, 32'h7FC00000);
        chk("to_flg", rsp_flags_o, 5'h10);
        chk("to_tmo", timeout_o, 1);
        take();
        chk("to_sticky", timeout_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
